// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: definitions shared across the mini-CPU front end.
//   - opcode constants and instruction field bit positions
//   - controller state encoding
//   - small decode helpers
package mini_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction layout: opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0]
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MUL_STALL = 2'd1,
        HALT      = 2'd2
    } ctrl_state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // NOP and HALT are the only instructions that read no source registers.
    function automatic logic uses_sources(input logic [3:0] opc);
        return (opc != OP_NOP) && (opc != OP_HALT);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Ports:
//   id_instr      in  16  instruction currently in IF/ID
//   idex_mem_read in  1   instruction in EX is a load
//   idex_rd       in  4   destination register of the instruction in EX
//   load_use      out 1   ID reads the register the EX load is writing
module hazard_detect
    import mini_cpu_pkg::*;
(
    input  logic [15:0] id_instr,
    input  logic        idex_mem_read,
    input  logic [3:0]  idex_rd,
    output logic        load_use
);

    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       src_use;
    logic       unused_rd_bits;

    assign rs1     = id_instr[RS1_MSB:RS1_LSB];
    assign rs2     = id_instr[RS2_MSB:RS2_LSB];
    assign src_use = uses_sources(opcode_of(id_instr));

    // The destination field plays no part in a load-use compare.
    assign unused_rd_bits = ^id_instr[RD_MSB:RD_LSB];

    // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = idex_mem_read && src_use && (idex_rd != 4'd0) &&
                      ((idex_rd == rs1) || (idex_rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and flow controller for the mini-CPU front end.
// Sequences load-use stalls, multi-cycle MUL stalls, branch-redirect flushes,
// instruction-memory wait states and HALT/resume.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   id_instr         instruction held in IF/ID
//   idex_mem_read    EX holds a load
//   idex_rd          EX destination register
//   ex_branch_taken  EX branch/jump resolved taken
//   imem_ready       instruction memory returns a valid word
//   resume           leave HALT
//   pc_we, pc_sel    PC update enable / select (0 = PC+1, 1 = branch target)
//   ifid_we          IF/ID load enable (0 = hold)
//   ifid_flush       load NOP into IF/ID (overrides ifid_we)
//   idex_bubble      load NOP into ID/EX
//   halted           controller is in HALT
// Optional (macro PIPE_CTRL_PERF_EN):
//   stall_cycles     saturating count of non-branch cycles with pc_we=0
//   flush_count      saturating count of branch flushes
module pipe_ctrl
    import mini_cpu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        idex_mem_read,
    input  logic [3:0]  idex_rd,
    input  logic        ex_branch_taken,
    input  logic        imem_ready,
    input  logic        resume,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [7:0]  flush_count
`endif
);

    // The first stall cycle is spent in RUN, so MUL_STALL needs MUL_LAT-1 more.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    ctrl_state_t state, next_state;
    logic [3:0]  mul_cnt, mul_cnt_next;
    logic [3:0]  opcode;
    logic        load_use;

    assign opcode = opcode_of(id_instr);

    hazard_detect u_hazard_detect (
        .id_instr      (id_instr),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .load_use      (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
        end else begin
            state   <= next_state;
            mul_cnt <= mul_cnt_next;
        end
    end

    always_comb begin
        next_state   = state;
        mul_cnt_next = mul_cnt;
        pc_we        = 1'b1;
        pc_sel       = 1'b0;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        halted       = (state == HALT);

        if (ex_branch_taken) begin
            // Redirect wins over everything, including a memory wait: the
            // fetched word is discarded by the flush anyway.
            pc_sel       = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            next_state   = RUN;
            mul_cnt_next = 4'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (opcode == OP_HALT) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        next_state  = HALT;
                    end else if (opcode == OP_MUL) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_bubble  = 1'b1;
                        mul_cnt_next = MUL_LOAD;
                        next_state   = MUL_STALL;
                    end else if (load_use) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                    // A held IF/ID keeps its word, so only an advancing ID
                    // needs a NOP in place of the missing fetch.
                    if (!imem_ready) begin
                        pc_we = 1'b0;
                        if (ifid_we) begin
                            ifid_flush = 1'b1;
                        end
                    end
                end
                MUL_STALL: begin
                    if (mul_cnt != 4'd0) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_bubble  = 1'b1;
                        mul_cnt_next = mul_cnt - 4'd1;
                    end else begin
                        // Release: the MUL enters EX and ID advances past it,
                        // so it is not seen again in RUN.
                        next_state = RUN;
                        if (!imem_ready) begin
                            pc_we      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                HALT: begin
                    idex_bubble = 1'b1;
                    if (resume) begin
                        // HALT is dropped from ID without ever reaching EX.
                        next_state = RUN;
                        if (!imem_ready) begin
                            pc_we      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end else begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                    end
                end
                default: begin
                    next_state   = RUN;
                    mul_cnt_next = 4'd0;
                end
            endcase
        end

        if (rst) begin
            pc_we       = 1'b0;
            pc_sel      = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            halted      = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            flush_count  <= 8'd0;
        end else begin
            if (!pc_we && !ex_branch_taken && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (ex_branch_taken && (flush_count != 8'hFF)) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (MUL_LAT = 3).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] id_instr;
    logic        idex_mem_read;
    logic [3:0]  idex_rd;
    logic        ex_branch_taken;
    logic        imem_ready;
    logic        resume;
    logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Output vector order: pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, halted
    localparam logic [5:0] EXP_RUN   = 6'b101000;
    localparam logic [5:0] EXP_STALL = 6'b000010;
    localparam logic [5:0] EXP_HALT  = 6'b000011;
    localparam logic [5:0] EXP_RESUM = 6'b101011;

    localparam logic [15:0] I_NOP  = 16'h0000;
    localparam logic [15:0] I_ADD  = 16'h1132;  // ADD r1, r3, r2
    localparam logic [15:0] I_ADD0 = 16'h1100;  // ADD r1, r0, r0
    localparam logic [15:0] I_MUL  = 16'hC123;
    localparam logic [15:0] I_HALT = 16'hF000;

    logic [5:0] outs;
    assign outs = {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, halted};

    pipe_ctrl #(.MUL_LAT(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_instr        (id_instr),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .resume          (resume),
        .pc_we           (pc_we),
        .pc_sel          (pc_sel),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled 1ns later, far from any edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic mr, input logic [3:0] rd,
                         input logic br, input logic rdy, input logic res);
        id_instr        = instr;
        idex_mem_read   = mr;
        idex_rd         = rd;
        ex_branch_taken = br;
        imem_ready      = rdy;
        resume          = res;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(I_MUL, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        checks++;
        if (outs !== 6'b000000) begin
            $display("[TB] FAIL reset_outputs_zero got=%b exp=%b", outs, 6'b000000);
            failures++;
        end
        tick();
        rst = 1'b0;
        drive(I_NOP, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_RUN) begin
            $display("[TB] FAIL reset_release_run got=%b exp=%b", outs, EXP_RUN);
            failures++;
        end
    endtask

    task automatic test_load_use();
        logic [5:0] exp_v [4] = '{EXP_STALL, EXP_RUN, EXP_RUN, EXP_STALL};
        logic [15:0] ins  [4] = '{I_ADD, I_ADD, I_ADD0, I_ADD};
        logic        mr   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  rd   [4] = '{4'd3, 4'd0, 4'd0, 4'd2};
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(ins[i], mr[i], rd[i], 1'b0, 1'b1, 1'b0);
            checks++;
            if (outs !== exp_v[i]) begin
                $display("[TB] FAIL load_use_step%0d got=%b exp=%b", i, outs, exp_v[i]);
                failures++;
            end
        end
        tick();
        drive(I_ADD, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_RUN) begin
            $display("[TB] FAIL load_use_r0 got=%b exp=%b", outs, EXP_RUN);
            failures++;
        end
    endtask

    task automatic test_mul();
        logic [5:0] exp_v [5] = '{EXP_STALL, EXP_STALL, EXP_STALL, EXP_RUN, EXP_RUN};
        for (int i = 0; i < 5; i++) begin
            tick();
            drive((i < 4) ? I_MUL : I_ADD, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (outs !== exp_v[i]) begin
                $display("[TB] FAIL mul_cycle%0d got=%b exp=%b", i, outs, exp_v[i]);
                failures++;
            end
        end
    endtask

    task automatic test_branch_mul();
        tick();
        drive(I_MUL, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_STALL) begin
            $display("[TB] FAIL brmul_first got=%b exp=%b", outs, EXP_STALL);
            failures++;
        end
        tick();
        drive(I_MUL, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({pc_we, pc_sel, ifid_flush, idex_bubble} !== 4'b1111) begin
            $display("[TB] FAIL brmul_redirect got=%b exp=%b",
                     {pc_we, pc_sel, ifid_flush, idex_bubble}, 4'b1111);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(I_NOP, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (outs !== EXP_RUN) begin
                $display("[TB] FAIL brmul_after%0d got=%b exp=%b", i, outs, EXP_RUN);
                failures++;
            end
        end
    endtask

    task automatic test_halt();
        tick();
        drive(I_HALT, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_STALL) begin
            $display("[TB] FAIL halt_detect got=%b exp=%b", outs, EXP_STALL);
            failures++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(I_HALT, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (outs !== EXP_HALT) begin
                $display("[TB] FAIL halt_hold%0d got=%b exp=%b", i, outs, EXP_HALT);
                failures++;
            end
        end
        tick();
        drive(I_HALT, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (outs !== EXP_RESUM) begin
            $display("[TB] FAIL halt_resume got=%b exp=%b", outs, EXP_RESUM);
            failures++;
        end
        tick();
        drive(I_ADD, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_RUN) begin
            $display("[TB] FAIL halt_after got=%b exp=%b", outs, EXP_RUN);
            failures++;
        end
        // Resume while instruction memory is waiting.
        tick();
        drive(I_HALT, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(I_HALT, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({pc_we, ifid_flush, idex_bubble, halted} !== 4'b0111) begin
            $display("[TB] FAIL halt_resume_wait got=%b exp=%b",
                     {pc_we, ifid_flush, idex_bubble, halted}, 4'b0111);
            failures++;
        end
    endtask

    task automatic test_imem_wait();
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(I_ADD, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({pc_we, pc_sel, ifid_flush, idex_bubble} !== 4'b0010) begin
                $display("[TB] FAIL imem_wait%0d got=%b exp=%b", i,
                         {pc_we, pc_sel, ifid_flush, idex_bubble}, 4'b0010);
                failures++;
            end
        end
        tick();
        drive(I_ADD, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0001) begin
            $display("[TB] FAIL imem_wait_loaduse got=%b exp=%b",
                     {pc_we, ifid_we, ifid_flush, idex_bubble}, 4'b0001);
            failures++;
        end
        tick();
        drive(I_ADD, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({pc_we, pc_sel, ifid_flush, idex_bubble} !== 4'b1111) begin
            $display("[TB] FAIL imem_wait_branch got=%b exp=%b",
                     {pc_we, pc_sel, ifid_flush, idex_bubble}, 4'b1111);
            failures++;
        end
        tick();
        drive(I_NOP, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_RUN) begin
            $display("[TB] FAIL imem_wait_after got=%b exp=%b", outs, EXP_RUN);
            failures++;
        end
    endtask

    task automatic test_rst_mid_mul();
        tick();
        drive(I_MUL, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(I_MUL, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        // Now in MUL_STALL with mul_cnt = 1.
        drive(I_MUL, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== EXP_STALL) begin
            $display("[TB] FAIL rstmul_pre got=%b exp=%b", outs, EXP_STALL);
            failures++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            $display("[TB] FAIL rstmul_asserted got=%b exp=%b", outs, 6'b000000);
            failures++;
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(I_NOP, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (outs !== EXP_RUN) begin
                $display("[TB] FAIL rstmul_after%0d got=%b exp=%b", i, outs, EXP_RUN);
                failures++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_branch_mul();
        test_halt();
        test_imem_wait();
        test_rst_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and flow controller for the mini-CPU front end. It decodes the instruction held in the IF/ID register, along with status from ID/EX, EX and instruction memory. From these it drives PC write-enable and select, IF/ID hold and flush, and ID/EX bubble insertion. It sequences load-use stalls, multi-cycle MUL stalls, branch-redirect flushes, instruction-memory wait states, and HALT/resume.

Parameters:
MUL_LAT, 3, total stall cycles charged to a MUL in ID (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_instr  input  16  IF/ID instruction_out; opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0]
idex_mem_read  input  1  instruction in EX is a load
idex_rd  input  4  destination register of the instruction in EX
ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
imem_ready  input  1  instruction memory returns a valid word this cycle
resume  input  1  leave HALT state
pc_we  output  1  PC register update enable
pc_sel  output  1  0 = PC+1, 1 = EX branch target
ifid_we  output  1  IF/ID load enable (0 = hold)
ifid_flush  output  1  load NOP (16'h0000) into IF/ID; overrides ifid_we
idex_bubble  output  1  load NOP into ID/EX instead of the decoded instruction
halted  output  1  controller is in HALT

Behaviour:
- FSM states: RUN, MUL_STALL, HALT. Async reset puts the FSM in RUN and clears the 4-bit mul_cnt.
- All outputs are combinational from state and inputs. While rst=1, every output is forced to 0.
- Hazard terms:
  - src_use is true for all opcodes except OP_NOP and OP_HALT.
  - load_use = idex_mem_read & src_use & idex_rd!=0 & (idex_rd==rs1 | idex_rd==rs2).
  - Register r0 never causes a hazard.
- Default outputs in RUN with no event: pc_we=1, pc_sel=0, ifid_we=1, ifid_flush=0, idex_bubble=0.
- Priority, highest first, in every state: branch > HALT handling > MUL stall > load-use > imem wait.
- branch (ex_branch_taken=1), any state:
  - Outputs: pc_we=1, pc_sel=1, ifid_flush=1, idex_bubble=1. The instruction in ID is squashed.
  - Next state RUN; mul_cnt cleared.
  - The redirect is taken even if imem_ready=0.
- RUN, opcode==OP_HALT:
  - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
  - Next state HALT.
- HALT:
  - halted=1, pc_we=0, ifid_we=0, idex_bubble=1.
  - When resume=1: the HALT is consumed (pc_we=1, ifid_we=1, idex_bubble=1); next state RUN.
- RUN, opcode==OP_MUL:
  - This cycle stalls: pc_we=0, ifid_we=0, idex_bubble=1.
  - mul_cnt is loaded with MUL_LAT-1; next state MUL_STALL.
- MUL_STALL, mul_cnt!=0: stall as above; mul_cnt decrements.
- MUL_STALL, mul_cnt==0:
  - Release: pc_we=1, ifid_we=1, idex_bubble=0. The MUL enters EX.
  - Next state RUN. The MUL is never re-detected.
  - Total bubbles per MUL = MUL_LAT.
- RUN, load_use: pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle. No state change; the bubble clears the hazard next cycle.
- RUN, imem_ready=0, ID advancing: pc_we=0, ifid_flush=1 (NOP fetched), ID instruction proceeds normally.
- RUN, imem_ready=0, ID stalled by another term: ifid_we=0, ifid_flush=0 (hold beats flush).
- MUL_STALL and HALT ignore load_use and imem_ready, except the release/resume cycle. In that cycle, if imem_ready=0, pc_we=0 and ifid_flush=1.
- rst asserted mid-stall: the FSM returns to RUN immediately and mul_cnt clears. No residual stall after rst deasserts.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined:
  - Adds output stall_cycles (16 bits): saturating count of cycles with pc_we=0 and ex_branch_taken=0.
  - Adds output flush_count (8 bits): saturating count of branch flushes.
  - Both counters are cleared by rst.
- Undefined: both ports and both counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package mini_cpu_pkg holds:
  - opcode constants: OP_NOP=4'h0, OP_LD=4'h8, OP_MUL=4'hC, OP_HALT=4'hF;
  - instruction field bit positions;
  - state encoding: RUN=2'd0, MUL_STALL=2'd1, HALT=2'd2.
- One sub-module, hazard_detect, contains the combinational load_use compare (id_instr, idex_mem_read, idex_rd -> load_use).

Test Plan:
- Load-use: LD r3 in EX (idex_mem_read=1, idex_rd=3), ID=ADD r1,r3,r2 -> one cycle of pc_we=0/ifid_we=0/idex_bubble=1, then normal flow. Same with idex_rd=0 -> no stall.
- MUL_LAT=3: MUL enters ID -> exactly 3 cycles of idex_bubble=1 and pc_we=0, 4th cycle pc_we=1 with idex_bubble=0, FSM back in RUN.
- Branch during MUL_STALL (2nd stall cycle, ex_branch_taken=1) -> pc_sel=1, pc_we=1, ifid_flush=1, idex_bubble=1 that cycle, RUN next, no further MUL bubbles.
- HALT in ID -> halted=1 and PC frozen for 10 cycles. resume=1 -> halted=0 next cycle, PC advances, no HALT reaches EX.
- imem_ready=0 for 2 cycles in RUN -> pc_we=0 and ifid_flush=1 both cycles. Combined with load-use -> ifid_we=0 and ifid_flush=0.
- rst pulse during MUL_STALL (mul_cnt=1) -> all outputs 0 while asserted. After release: RUN, no stall unless a new hazard is present.
